// File: rtl/logic_issue_pkg.sv
// Shared constants for the integer logic issue path.
//   data_size    : operand/result width
//   FUNCT3_*     : RISC-V funct3 codes of the bitwise ops
//   SEL_*        : 4-bit truth-table selects understood by logic_mod
//   s1_op_t      : operand/select record held in stage 1
package logic_issue_pkg;

    localparam int data_size = 32;

    localparam logic [2:0] FUNCT3_AND = 3'b111;
    localparam logic [2:0] FUNCT3_OR  = 3'b110;
    localparam logic [2:0] FUNCT3_XOR = 3'b100;

    // Bit {a,b} of the select is the result bit for operand bits a,b.
    localparam logic [3:0] SEL_AND = 4'b1000;
    localparam logic [3:0] SEL_OR  = 4'b1110;
    localparam logic [3:0] SEL_XOR = 4'b0110;

    typedef struct packed {
        logic [data_size-1:0] op1;
        logic [data_size-1:0] op2;
        logic [3:0]           sel;
        logic                 illegal;
    } s1_op_t;

endpackage

// File: rtl/logic_mod.sv
// Bitwise truth-table unit: each result bit is sel[{a[i], b[i]}].
//   a, b : operands
//   sel  : 4-bit truth table
//   y    : result
module logic_mod #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [3:0]   sel,
    output logic [W-1:0] y
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign y[i] = sel[{a[i], b[i]}];
    end

endmodule

// File: rtl/logic_issue.sv
// Issue-side driver for the bitwise logic path. Two-stage valid/ready pipe:
// S1 captures operands + decoded select, S2 captures the logic_mod result
// and presents it to the writeback arbiter.
//   clk, rst_n         : clock, async active-low reset
//   flush              : kill all in-flight ops at next edge
//   in_valid/in_ready  : decode handshake
//   in_funct3, in_rs1, in_rs2, in_imm, in_use_imm, in_rd : decoded op
//   wb_valid/wb_ready  : writeback handshake
//   wb_data, wb_rd, wb_illegal : writeback payload
module logic_issue
    import logic_issue_pkg::*;
#(
    parameter int tag_size = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_funct3,
    input  logic [data_size-1:0] in_rs1,
    input  logic [data_size-1:0] in_rs2,
    input  logic [data_size-1:0] in_imm,
    input  logic                 in_use_imm,
    input  logic [tag_size-1:0]  in_rd,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [data_size-1:0] wb_data,
    output logic [tag_size-1:0]  wb_rd,
    output logic                 wb_illegal
);

    // Returns {illegal, sel}.
    function automatic logic [4:0] decode_f3(input logic [2:0] f3);
        case (f3)
            FUNCT3_AND: return {1'b0, SEL_AND};
            FUNCT3_OR:  return {1'b0, SEL_OR};
            FUNCT3_XOR: return {1'b0, SEL_XOR};
            default:    return {1'b1, 4'b0000};
        endcase
    endfunction

    logic                 s1_valid_q, s1_valid_d;
    s1_op_t               s1_op_q, s1_op_d;
    logic [tag_size-1:0]  s1_rd_q, s1_rd_d;

    logic                 s2_valid_q, s2_valid_d;
    logic [data_size-1:0] s2_data_q, s2_data_d;
    logic [tag_size-1:0]  s2_rd_q, s2_rd_d;
    logic                 s2_illegal_q, s2_illegal_d;

    logic                 s2_free, s1_adv, accept;
    logic [data_size-1:0] lm_y;
    logic [4:0]           dec;

    assign s2_free  = !s2_valid_q || wb_ready;
    assign s1_adv   = s1_valid_q && s2_free;
    assign in_ready = (!s1_valid_q || s2_free) && !flush;
    assign accept   = in_valid && in_ready;
    assign dec      = decode_f3(in_funct3);

    logic_mod #(.W(data_size)) u_logic_mod (
        .a   (s1_op_q.op1),
        .b   (s1_op_q.op2),
        .sel (s1_op_q.sel),
        .y   (lm_y)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_rd_d    = s1_rd_q;
        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (accept) begin
            s1_valid_d      = 1'b1;
            s1_op_d.op1     = in_rs1;
            s1_op_d.op2     = in_use_imm ? in_imm : in_rs2;
            s1_op_d.sel     = dec[3:0];
            s1_op_d.illegal = dec[4];
            s1_rd_d         = in_rd;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d   = s2_valid_q;
        s2_data_d    = s2_data_q;
        s2_rd_d      = s2_rd_q;
        s2_illegal_d = s2_illegal_q;
        if (flush) begin
            s2_valid_d = 1'b0;
        end else if (s1_adv) begin
            s2_valid_d   = 1'b1;
            // x0 writes and illegal ops carry a zero payload.
            s2_data_d    = (s1_op_q.illegal || s1_rd_q == '0) ? '0 : lm_y;
            s2_rd_d      = s1_rd_q;
            s2_illegal_d = s1_op_q.illegal;
        end else if (wb_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_op_q      <= '0;
            s1_rd_q      <= '0;
            s2_valid_q   <= 1'b0;
            s2_data_q    <= '0;
            s2_rd_q      <= '0;
            s2_illegal_q <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_op_q      <= s1_op_d;
            s1_rd_q      <= s1_rd_d;
            s2_valid_q   <= s2_valid_d;
            s2_data_q    <= s2_data_d;
            s2_rd_q      <= s2_rd_d;
            s2_illegal_q <= s2_illegal_d;
        end
    end

    assign wb_valid   = s2_valid_q;
    assign wb_data    = s2_data_q;
    assign wb_rd      = s2_rd_q;
    assign wb_illegal = s2_illegal_q;

endmodule

// File: doc/logic_issue.md
# logic_issue

Issue-side driver for the integer execution unit's bitwise logic path. It accepts decoded RISC-V logic instructions (AND/ANDI, OR/ORI, XOR/XORI) from decode, selects operands, and translates funct3 into the 4-bit truth-table select consumed by `logic_mod`. It then collects the result into a registered writeback slot. It is a two-stage valid/ready pipeline between decode and the register-file writeback arbiter.

## Interface
- `data_size`, from constants.sv: operand/result width.
- `tag_size`, 5: destination register index width.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  synchronous kill of all in-flight ops.
- `in_valid`  in  1  decode offers an op.
- `in_ready`  out  1  block accepts the op this cycle.
- `in_funct3`  in  3  RISC-V funct3.
- `in_rs1`  in  data_size  rs1 value.
- `in_rs2`  in  data_size  rs2 value.
- `in_imm`  in  data_size  sign-extended I-immediate.
- `in_use_imm`  in  1  1 selects `in_imm` as op2 (I-type).
- `in_rd`  in  tag_size  destination register.
- `wb_valid`  out  1  writeback slot holds a result.
- `wb_ready`  in  1  arbiter takes the result.
- `wb_data`  out  data_size  result.
- `wb_rd`  out  tag_size  destination register.
- `wb_illegal`  out  1  funct3 was not a logic op.

## Operation
- Funct3 to `logic_sel` mapping. The select bit indexed by {op1 bit, op2 bit} is the output bit.
  - 3'b111 AND maps to 4'b1000.
  - 3'b110 OR maps to 4'b1110.
  - 3'b100 XOR maps to 4'b0110.
  - Any other funct3 maps to 4'b0000, with the illegal flag set.
- Stage 1 (S1) registers op1 = `in_rs1`, op2 = `in_use_imm` ? `in_imm` : `in_rs2`, logic_sel, rd and the illegal flag. It drives the internal `logic_mod` from these registers.
- Stage 2 (S2) registers the `logic_mod` output together with S1's rd and illegal flag. It drives the `wb_*` outputs.
- If rd == 0, `wb_data` is forced to all zeros. `wb_valid` is still raised.
- If the op is illegal, `wb_data` is all zeros and `wb_illegal` = 1.
- Handshake:
  - s2_free = !s2_valid || wb_ready.
  - s1_adv = s1_valid && s2_free.
  - `in_ready` = (!s1_valid || s2_free) && !flush.
  - S1 loads on `in_valid` && `in_ready`.
  - S2 loads on s1_adv.
  - S2 clears on wb_ready && !s1_adv.
- Once `wb_valid` rises, `wb_data`, `wb_rd` and `wb_illegal` hold stable until the cycle in which `wb_ready` is sampled high.
- `flush` clears s1_valid and s2_valid at the next edge and blocks acceptance that cycle. `flush` overrides every simultaneous load or advance.

## Timing
- Reset values:
  - `in_ready` = 1 (combinational from cleared state).
  - `wb_valid` = 0.
  - `wb_data` = 0.
  - `wb_rd` = 0.
  - `wb_illegal` = 0.
  - All S1/S2 registers = 0.
- Latency: an op accepted at edge N has `wb_valid` = 1 from edge N+1 onward when the writeback side is unstalled. That is two register stages from the input, i.e. the result is visible in the cycle after S1 captures.
- Throughput: one op per cycle while `wb_ready` = 1.
- Full: when S1 and S2 are both valid and `wb_ready` = 0, `in_ready` = 0 combinationally in that same cycle.
- Simultaneous accept and drain: when the pipe is full and `wb_ready` = 1, S2 takes S1, S1 takes the new op, and no bubble is inserted.
- `rst_n` asserted mid-operation drops all ops immediately and asynchronously. No partial writeback is emitted after reset is released.
- No combinational path from `in_*` to `wb_*`. `in_ready` depends on `wb_ready` combinationally.

## Structure
- constants.sv holds:
  - `data_size`;
  - the funct3 codes FUNCT3_AND/OR/XOR;
  - the select constants SEL_AND = 4'b1000, SEL_OR = 4'b1110, SEL_XOR = 4'b0110.
- One sub-module is instantiated: `logic_mod`, fed from the S1 registers.
- The funct3-to-select mapping is a local combinational function. It is not a separate module.

## Test plan
- Reset and single AND:
  - Stimulus: release reset; send funct3 = 111, rs1 = 0xF0F0_F0F0, rs2 = 0xFF00_FF00, rd = 5, `wb_ready` held at 1.
  - Required response: `wb_valid` for exactly one cycle with `wb_data` = 0xF000_F000, `wb_rd` = 5, `wb_illegal` = 0.
- XORI with immediate, followed by back-to-back OR:
  - Stimulus: XORI with `in_use_imm` = 1, imm = 0xFFFF_FFFF, rs1 = 0x1234_5678; then on the next cycle OR with rs1 = 0x1, rs2 = 0x2, rd = 3.
  - Required response: results 0xEDCB_A987 and 0x3 on consecutive cycles, with no bubble.
- Backpressure:
  - Stimulus: hold `wb_ready` = 0 and offer three ops.
  - Required response: the first two are accepted, `in_ready` = 0 on the third, and `wb_*` stays stable.
  - Then raise `wb_ready`: results drain in order and the third op is accepted on the drain cycle.
- Illegal funct3 and rd = 0:
  - Stimulus: funct3 = 010.
  - Required response: `wb_illegal` = 1, `wb_data` = 0.
  - Stimulus: a legal OR with rd = 0 and nonzero operands.
  - Required response: `wb_data` = 0, `wb_valid` = 1.
- Flush with a full pipe:
  - Stimulus: fill both stages with `wb_ready` = 0, assert `flush` together with `in_valid`.
  - Required response: the next cycle has `wb_valid` = 0, the offered op is not accepted, and no stale result ever appears.
- Asynchronous reset mid-stream:
  - Stimulus: drop `rst_n` between clock edges while `wb_valid` = 1.
  - Required response: `wb_valid` falls before the next edge, and all outputs read zero after release.
